// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: one read or write burst at a time, served from an internal word array.
// Optional define ADDR_CHECK_EN flags start addresses beyond the array as SLVERR.
module axi_mem_responder #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);
   localparam int IW  = $clog2(MEM_WORDS);
   localparam int OFS = $clog2(DATA_WIDTH / 8);
   localparam logic [2:0] FULL_SIZE = 3'(OFS);
   localparam logic [1:0] B_FIXED = 2'b00, B_WRAP = 2'b10;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [7:0]            len_q, len_d, cnt_q, cnt_d;
   logic [1:0]            burst_q, burst_d, bresp_q, bresp_d, rresp_q, rresp_d;
   logic                  err_q, err_d, awready_q, awready_d, wready_q, wready_d;
   logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0] rd_word;
   logic [IW-1:0]         start_idx, rd_idx;
   logic [7:0]            start_len;
   logic [1:0]            start_burst;
   logic                  start_err, mem_we, aw_hs, ar_hs, w_hs, r_hs, last_beat;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{s_axi_awaddr[OFS-1:0], s_axi_araddr[OFS-1:0],
                               s_axi_awaddr[ADDR_WIDTH-1:OFS+IW], s_axi_araddr[ADDR_WIDTH-1:OFS+IW]};

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // WRAP with an illegal length has already raised err and walks like INCR.
   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx, input logic [1:0] burst,
                                              input logic [7:0] len);
      logic [IW-1:0] inc;
      logic [IW-1:0] mask;
      inc  = idx + 1'b1;
      mask = IW'(len);
      if (burst == B_FIXED)
         return idx;
      else if (burst == B_WRAP && wrap_len_ok(len))
         return (idx & ~mask) | (inc & mask);
      else
         return inc;
   endfunction

   // Descriptor presented in IDLE; AW has priority over AR.
   always_comb begin
      start_idx   = s_axi_awvalid ? s_axi_awaddr[OFS +: IW] : s_axi_araddr[OFS +: IW];
      start_len   = s_axi_awvalid ? s_axi_awlen   : s_axi_arlen;
      start_burst = s_axi_awvalid ? s_axi_awburst : s_axi_arburst;
      start_err   = ((s_axi_awvalid ? s_axi_awsize : s_axi_arsize) != FULL_SIZE) ||
                    (start_burst == B_WRAP && !wrap_len_ok(start_len));
`ifdef ADDR_CHECK_EN
      if (s_axi_awvalid ? (|s_axi_awaddr[ADDR_WIDTH-1:OFS+IW]) : (|s_axi_araddr[ADDR_WIDTH-1:OFS+IW]))
         start_err = 1'b1;
`else
`endif
      rd_idx = (state_q == IDLE) ? start_idx : next_idx(idx_q, burst_q, len_q);
   end

   assign rd_word = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[idx_q] <= s_axi_wdata;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      burst_d   = burst_q;
      err_d     = err_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rlast_d   = rlast_q;
      rresp_d   = rresp_q;
      mem_we    = 1'b0;
      aw_hs     = awready_q & s_axi_awvalid;
      ar_hs     = awready_q & s_axi_arvalid & ~s_axi_awvalid;
      w_hs      = wready_q & s_axi_wvalid;
      r_hs      = rvalid_q & s_axi_rready;
      last_beat = (cnt_q == len_q);
      case (state_q)
         IDLE: begin
            if (aw_hs || ar_hs) begin
               state_d = aw_hs ? WDATA : RDATA;
               idx_d   = start_idx;
               len_d   = start_len;
               burst_d = start_burst;
               cnt_d   = 8'd0;
               err_d   = start_err;
            end
            if (ar_hs) begin
               rvalid_d = 1'b1;
               rdata_d  = start_err ? '0 : rd_word;
               rlast_d  = (start_len == 8'd0);
               rresp_d  = start_err ? SLVERR : OKAY;
            end
         end
         WDATA: begin
            if (w_hs) begin
               mem_we = ~err_q;
               err_d  = err_q | (s_axi_wlast != last_beat);
               if (last_beat) begin
                  state_d  = WRESP;
                  bvalid_d = 1'b1;
                  bresp_d  = err_d ? SLVERR : OKAY;
               end else begin
                  cnt_d = cnt_q + 8'd1;
                  idx_d = next_idx(idx_q, burst_q, len_q);
               end
            end
         end
         WRESP: begin
            if (s_axi_bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         RDATA: begin
            if (r_hs) begin
               if (rlast_q) begin
                  rvalid_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  cnt_d   = cnt_q + 8'd1;
                  idx_d   = rd_idx;
                  rdata_d = err_q ? '0 : rd_word;
                  rlast_d = (cnt_d == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      awready_d = (state_d == IDLE);
      wready_d  = (state_d == WDATA);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         burst_q   <= '0;
         err_q     <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rlast_q   <= 1'b0;
         rresp_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         burst_q   <= burst_d;
         err_q     <= err_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rlast_q   <= rlast_d;
         rresp_q   <= rresp_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_arready = awready_q & ~s_axi_awvalid;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rresp   = rresp_q;
endmodule
